// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framing stage.
//   state_t            : framing FSM state encoding (BREAK_WAIT is only reachable
//                        when UART_RX_BREAK_DETECT_EN is defined)
//   PARITY_EVEN/ODD    : par_type encodings
//   DEFAULT_DATA_WIDTH : default number of data bits per frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DATA       = 3'd1,
        PARITY     = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_frame_fsm.sv
// UART receive framing FSM, fed by the oversampler's per-bit tick.
// Detects the start bit, assembles DATA_WIDTH data bits LSB first, an optional
// parity bit and one stop bit, then reports the frame with registered
// one-clock pulses.
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN
//   defined   : an all-zero frame (data, parity, stop) raises break_det together
//               with framing_error and parks the FSM in BREAK_WAIT until a 1 tick.
//   undefined : break_det is tied 0; an all-zero frame is only a framing error.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   bit_tick      one-clock pulse per bit period
//   bit_in        voted bit value, valid with bit_tick
//   par_en        frame carries a parity bit (latched at start bit)
//   par_type      0 = even, 1 = odd parity (latched at start bit)
//   rx_data       last good frame's data
//   rx_valid      one-clock pulse, rx_data updated
//   parity_error  one-clock pulse with rx_valid on parity mismatch
//   framing_error one-clock pulse, stop bit sampled 0
//   busy          FSM not idle
//   break_det     one-clock pulse on line break
module uart_rx_frame_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_tick,
    input  logic                  bit_in,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy,
    output logic                  break_det
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  cfg_pen, cfg_pen_n;
    logic                  cfg_ptype, cfg_ptype_n;
    logic                  par_bit, par_bit_n;
    logic [DATA_WIDTH-1:0] rx_data_n;
    logic                  rx_valid_n, parity_error_n, framing_error_n;

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_q, brk_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            shreg         <= '0;
            cfg_pen       <= 1'b0;
            cfg_ptype     <= PARITY_EVEN;
            par_bit       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q         <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            shreg         <= shreg_n;
            cfg_pen       <= cfg_pen_n;
            cfg_ptype     <= cfg_ptype_n;
            par_bit       <= par_bit_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            parity_error  <= parity_error_n;
            framing_error <= framing_error_n;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q         <= brk_n;
`endif
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        shreg_n         = shreg;
        cfg_pen_n       = cfg_pen;
        cfg_ptype_n     = cfg_ptype;
        par_bit_n       = par_bit;
        rx_data_n       = rx_data;
        rx_valid_n      = 1'b0;
        parity_error_n  = 1'b0;
        framing_error_n = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_n           = 1'b0;
`endif
        if (bit_tick) begin
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        // Parity config is frozen for the whole frame here.
                        state_n     = DATA;
                        cnt_n       = '0;
                        cfg_pen_n   = par_en;
                        cfg_ptype_n = par_type;
                        par_bit_n   = 1'b0;
                    end
                end
                DATA: begin
                    // Right shift: first received bit ends up in bit 0.
                    shreg_n = {bit_in, shreg[DATA_WIDTH-1:1]};
                    cnt_n   = cnt + 1'b1;
                    if (cnt == LAST_BIT)
                        state_n = cfg_pen ? PARITY : STOP;
                end
                PARITY: begin
                    par_bit_n = bit_in;
                    state_n   = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (bit_in) begin
                        rx_data_n      = shreg;
                        rx_valid_n     = 1'b1;
                        parity_error_n = cfg_pen && (par_bit != ((^shreg) ^ cfg_ptype));
                    end else begin
                        framing_error_n = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (shreg == '0 && !(cfg_pen && par_bit)) begin
                            brk_n   = 1'b1;
                            state_n = BREAK_WAIT;
                        end
`endif
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BREAK_WAIT: begin
                    // Hold off re-arming until the line returns to idle.
                    if (bit_in)
                        state_n = IDLE;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det = brk_q;
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Self-checking bench for uart_rx_frame_fsm: directed frames from the test plan
// followed by random frames compared against a frame-level reference model.
module tb_uart_rx_frame_fsm;

    localparam int DW = 8;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          bit_tick = 1'b0;
    logic          bit_in = 1'b1;
    logic          par_en = 1'b0;
    logic          par_type = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid, parity_error, framing_error, busy, break_det;

    int passed = 0;
    int total  = 0;
    logic [DW-1:0] exp_data = '0;

    always #5 clk = ~clk;

    uart_rx_frame_fsm #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bit_tick(bit_tick), .bit_in(bit_in),
        .par_en(par_en), .par_type(par_type), .rx_data(rx_data),
        .rx_valid(rx_valid), .parity_error(parity_error),
        .framing_error(framing_error), .busy(busy), .break_det(break_det)
    );

    // {rx_valid, parity_error, framing_error, break_det, busy}
    function automatic logic [4:0] st();
        return {rx_valid, parity_error, framing_error, break_det, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One tick, at least 2 clk after the previous one; returns #1 after the edge.
    task automatic tick(input logic b);
        repeat ($urandom_range(2, 4)) @(negedge clk);
        bit_tick = 1'b1;
        bit_in   = b;
        @(posedge clk);
        #1;
        bit_tick = 1'b0;
        bit_in   = 1'($urandom);
    endtask

    // Sends a full frame and checks it against the frame-level model.
    task automatic send_frame(input logic [DW-1:0] data, input logic pen,
                              input logic ptype, input logic pbit, input logic stop);
        logic brk;
        logic [4:0] exp_st;
        par_en   = pen;
        par_type = ptype;
        tick(1'b0);
        chk("start_busy", 32'(st()), 32'(5'b00001));
        // Mid-frame config changes must not matter.
        par_en   = 1'($urandom);
        par_type = 1'($urandom);
        for (int i = 0; i < DW; i++) begin
            tick(data[i]);
            chk("data_busy", 32'(st()), 32'(5'b00001));
        end
        if (pen) begin
            tick(pbit);
            chk("par_busy", 32'(st()), 32'(5'b00001));
        end
        tick(stop);
        brk = 1'b0;
        if (stop) begin
            exp_data = data;
            exp_st   = {1'b1, pen && (pbit != ((^data) ^ ptype)), 3'b000};
        end else begin
            brk    = BRK_EN && (data == '0) && !(pen && pbit);
            exp_st = {2'b00, 1'b1, brk, brk};
        end
        chk("frame_end", 32'(st()), 32'(exp_st));
        chk("rx_data", 32'(rx_data), 32'(exp_data));
        @(posedge clk);
        #1;
        chk("pulse_1clk", 32'(st()), 32'({4'b0000, brk}));
        // After an all-zero framing error, a 1 tick returns to idle in either build.
        if (!stop && data == '0 && !(pen && pbit)) begin
            tick(1'b1);
            chk("brk_exit", 32'(st()), 32'(5'b00000));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_data = '0;
        chk("rst_state", 32'(st()), 32'(5'b00000));
        chk("rst_data", 32'(rx_data), 32'(exp_data));
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("por_state", 32'(st()), 32'(5'b00000));
        chk("por_data", 32'(rx_data), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 8N1 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        // Even parity, data 0x03: parity bit 1 mismatches, 0 matches
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
        // Framing error keeps previous data
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

        // Line low without ticks, then idle ticks
        @(negedge clk);
        bit_in = 1'b0;
        repeat (50) begin
            @(negedge clk);
            total++;
            assert (st() === 5'b00000) passed++;
            else $error("FAIL no_tick_idle: observed %0h expected 0", st());
        end
        repeat (20) begin
            tick(1'b1);
            chk("idle_ticks", 32'(st()), 32'(5'b00000));
        end

        // Reset after 4 data bits, then a clean frame
        par_en = 1'b0;
        tick(1'b0);
        for (int i = 0; i < 4; i++) tick(1'($urandom));
        chk("mid_busy", 32'(st()), 32'(5'b00001));
        do_reset();
        @(posedge clk);
        #1;
        chk("post_rst_quiet", 32'(st()), 32'(5'b00000));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

        // Break sequence: all-zero frame, 3 more 0 ticks, then a 1 tick
        par_en = 1'b0;
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk("brk_frame", 32'(st()), 32'({3'b001, BRK_EN, BRK_EN}));
        chk("brk_data", 32'(rx_data), 32'(exp_data));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            chk("brk_hold", 32'(st()), 32'(5'b00001));
        end
        tick(1'b1);
        // Without break detect the 0 ticks started a new frame that is still running.
        chk("brk_release", 32'(st()), 32'({4'b0000, !BRK_EN}));
        do_reset();

        // Random frames
        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                tick(1'b1);
                chk("rand_idle", 32'(st()), 32'(5'b00000));
            end
            send_frame(d, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? 1'b0 : 1'($urandom),
                       ($urandom_range(0, 4) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_fsm.md
Name: uart_rx_frame_fsm

Overview:
UART receive framing stage, directly downstream of the N-times oversampler. Consumes the oversampler's once-per-bit-period tick and majority-voted bit. Detects the start bit and assembles DATA_WIDTH data bits, LSB first, plus an optional parity bit and one stop bit. Outputs a received byte with a one-clock valid pulse, and one-clock parity and framing error pulses.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9)

Ports:
clk  input  1  system clock, same domain as the oversampler
rst  input  1  asynchronous, active-low reset
bit_tick  input  1  one-clk pulse per bit period (oversampler tick); consecutive pulses at least 2 clk apart
bit_in  input  1  voted value of the most recently completed bit period; only meaningful when bit_tick=1
par_en  input  1  1 = frame carries a parity bit
par_type  input  1  0 = even parity, 1 = odd parity
rx_data  output  DATA_WIDTH  last good frame's data; holds until next good frame
rx_valid  output  1  one-clk pulse: rx_data updated
parity_error  output  1  one-clk pulse, coincident with rx_valid, on parity mismatch
framing_error  output  1  one-clk pulse: stop bit sampled 0
busy  output  1  1 whenever state != IDLE
break_det  output  1  one-clk pulse on line break (see Optional Feature); tied 0 when feature is absent

Behaviour:
- Reset (async, rst=0): state=IDLE; bit counter=0; shift register=0; rx_data=0; all pulse outputs=0; busy=0. Reset mid-frame aborts the frame and raises no pulse.
- The FSM advances only on cycles with bit_tick=1; all other cycles hold state.
- States: IDLE, DATA, PARITY, STOP.
- IDLE, tick, bit_in=0: start bit consumed; latch par_en/par_type into internal config; clear bit counter; go to DATA.
- IDLE, tick, bit_in=1: stay in IDLE.
- DATA, tick: shift bit_in into the MSB of the shift register (right shift, so LSB first); increment the counter.
  - After the DATA_WIDTH-th bit: go to PARITY if latched par_en=1, else go to STOP.
- PARITY, tick: store the received parity bit; go to STOP.
  - Expected parity = XOR-reduction(data) XOR par_type.
- STOP, tick, bit_in=1: on the next clk edge, load rx_data and assert rx_valid for exactly 1 clk.
  - parity_error=1 in the same cycle if parity is enabled and mismatched.
  - Go to IDLE.
- STOP, tick, bit_in=0: framing_error for 1 clk at the next edge; no rx_valid; rx_data unchanged; go to IDLE.
- Pulse outputs are registered: latency is 1 clk after the STOP tick edge.
- Changes to par_en/par_type mid-frame are ignored until the next start bit.
- A 0 sampled on the first tick after a framing error is treated as a new start bit (no feature macro).
- Bit counter width is $clog2(DATA_WIDTH+1); it never wraps within a frame.

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined: a frame whose data bits, parity bit (if enabled) and stop bit are all 0 is a break.
  - framing_error and break_det pulse together for 1 clk.
  - FSM enters an extra state BREAK_WAIT and stays there until a tick with bit_in=1, then goes to IDLE.
  - While in BREAK_WAIT, busy=1.
- Not defined: break_det is constant 0. An all-zero frame gives framing_error only, followed by an immediate re-start on the next 0 tick.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE, DATA, PARITY, STOP, BREAK_WAIT); PARITY_EVEN=0, PARITY_ODD=1; default DATA_WIDTH.
- No sub-module. Parity is an inline XOR reduction and the shift register is trivial; the block is a single FSM module.

Test Plan:
- 8N1, par_en=0, ticks carry 0,1,0,1,0,0,1,0,1,1 -> rx_data=0xA5, rx_valid 1 clk after the 10th tick, no errors, busy low afterwards.
- par_en=1, par_type=0, data 0x03, parity bit 1, stop 1 -> rx_valid=1 and parity_error=1 in the same cycle, rx_data=0x03. Repeat with parity bit 0 -> parity_error=0.
- 8N1 frame 0x3C with stop bit 0 -> framing_error pulse, rx_valid stays 0, rx_data keeps its previous value.
- bit_in=0 held with no ticks for 50 clk, then 20 ticks with bit_in=1 -> state stays IDLE, busy=0, no pulses.
- Assert rst after 4 data bits of a frame -> busy=0 and no pulse. Then a full frame of 0x5A -> rx_data=0x5A, rx_valid, no errors.
- With UART_RX_BREAK_DETECT_EN defined: 10 ticks with bit_in=0 -> framing_error and break_det pulse together; 3 further 0 ticks -> busy=1, no new frame; a tick with 1 -> IDLE. Without the macro, the same stimulus gives framing_error only and break_det stays 0.
